alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_sequencer_alu.sv | 50 +++++
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM state encoding,
// ALU opcodes, status-bit positions and the signed-overflow helper.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;

    // Overflow of a two's-complement addition, given the operand and result sign bits.
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational 16-bit ALU: ADD, SUB, AND, NOT(B) with {N,V,Z} flags.
module alu_sequencer_alu
    import alu_seq_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y,
    output logic [2:0]        o_status
);

    logic w_v;

    // Operation select; SUB overflow is ADD overflow against the inverted B sign.
    always_comb begin
        o_y = {DATA_W{1'b0}};
        w_v = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_y = i_a + i_b;
                w_v = signed_ovf(i_a[DATA_W-1], i_b[DATA_W-1], o_y[DATA_W-1]);
            end
            OP_SUB: begin
                o_y = i_a - i_b;
                w_v = signed_ovf(i_a[DATA_W-1], ~i_b[DATA_W-1], o_y[DATA_W-1]);
            end
            OP_AND: begin
                o_y = i_a & i_b;
                w_v = 1'b0;
            end
            OP_NOT: begin
                o_y = ~i_b;
                w_v = 1'b0;
            end
            default: begin
                o_y = {DATA_W{1'b0}};
                w_v = 1'b0;
            end
        endcase
    end

    // Flag assembly in the packed {N,V,Z} layout.
    always_comb begin
        o_status         = 3'b000;
        o_status[STAT_N] = o_y[DATA_W-1];
        o_status[STAT_V] = w_v;
        o_status[STAT_Z] = (o_y == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/alu_sequencer.sv
// Five-state ALU sequencer: operands are fetched from a local 8x16 register
// file, executed through the ALU and optionally written back.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [IDX_W-1:0]  req_rn,
    input  logic [IDX_W-1:0]  req_rm,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic              req_wb,
    input  logic              ext_we,
    input  logic [IDX_W-1:0]  ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        status
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_op;
    logic [IDX_W-1:0]    r_rn;
    logic [IDX_W-1:0]    r_rm;
    logic [IDX_W-1:0]    r_rd;
    logic                r_wb;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_c;
    logic [2:0]          r_status;
    logic [DATA_W-1:0]   r_rf [REG_N];
    logic                w_accept;
    logic [DATA_W-1:0]   w_alu_y;
    logic [2:0]          w_alu_status;

    // r_ready mirrors "state is IDLE", so it doubles as the acceptance gate.
    assign w_accept  = req_valid && r_ready;
    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_c;
    assign status    = r_status;

    // Next-state logic: fixed one-cycle walk through the pipeline states.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = LOADA;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOADA:   w_state_next = LOADB;
            LOADB:   w_state_next = EXEC;
            EXEC:    w_state_next = WRITE;
            WRITE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register with handshake/status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == IDLE);
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == WRITE);
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= 2'b00;
            r_rn <= {IDX_W{1'b0}};
            r_rm <= {IDX_W{1'b0}};
            r_rd <= {IDX_W{1'b0}};
            r_wb <= 1'b0;
        end else if (w_accept) begin
            r_op <= req_op;
            r_rn <= req_rn;
            r_rm <= req_rm;
            r_rd <= req_rd;
            r_wb <= req_wb;
        end
    end

    // Operand fetch and execute; C and status hold until the next EXEC exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= {DATA_W{1'b0}};
            r_b      <= {DATA_W{1'b0}};
            r_c      <= {DATA_W{1'b0}};
            r_status <= 3'b000;
        end else begin
            case (r_state)
                LOADA: r_a <= r_rf[r_rn];
                LOADB: r_b <= r_rf[r_rm];
                EXEC: begin
                    r_c      <= w_alu_y;
                    r_status <= w_alu_status;
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    // Register file: external writes only in IDLE, write-back only leaving WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                r_rf[i] <= {DATA_W{1'b0}};
            end
        end else if ((r_state == IDLE) && ext_we) begin
            r_rf[ext_addr] <= ext_data;
        end else if ((r_state == WRITE) && r_wb) begin
            r_rf[r_rd] <= r_c;
        end
    end

    alu_sequencer_alu u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_y      (w_alu_y),
        .o_status (w_alu_status)
    );

endmodule
